// File: rtl/gcd_operand_queue_if.sv
// Producer/core handshake bundle for gcd_operand_queue.
// Carries the optional `level` signal when GCD_OPQ_LEVEL_EN is defined.
interface gcd_operand_queue_if #(
  parameter int width = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_A;
  logic [width-1:0] in_B;
  logic [width-1:0] operand_A;
  logic [width-1:0] operand_B;
  logic             input_ready;
  logic             input_available;
  logic [15:0]      issue_cnt;
`ifdef GCD_OPQ_LEVEL_EN
  logic [ADDR_W:0]  level;
`endif

  modport master (
    output flush, in_valid, in_A, in_B, input_available,
    input  in_ready, operand_A, operand_B, input_ready, issue_cnt
`ifdef GCD_OPQ_LEVEL_EN
    , input level
`endif
  );

  modport slave (
    input  flush, in_valid, in_A, in_B, input_available,
    output in_ready, operand_A, operand_B, input_ready, issue_cnt
`ifdef GCD_OPQ_LEVEL_EN
    , output level
`endif
  );
endinterface

// File: rtl/gcd_operand_queue.sv
// Operand-pair FIFO feeding the GCD core, with a wrapping issue counter.
// Define GCD_OPQ_LEVEL_EN to expose the occupancy as bus.level.
module gcd_operand_queue #(
  parameter int width = 8,
  parameter int DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  gcd_operand_queue_if.slave   bus
);
  localparam int              ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W+1)'(DEPTH);

  logic [width-1:0]  mem_a_q [DEPTH];
  logic [width-1:0]  mem_b_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              full, empty, push, pop;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = ~empty & bus.input_available;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (bus.flush) begin
      // flush discards the in-flight transfer, so the counter is left alone
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        cnt_d    = cnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + (ADDR_W+1)'(1);
        2'b01:   occ_d = occ_q - (ADDR_W+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
    end else if (push && !bus.flush) begin
      mem_a_q[wr_ptr_q] <= bus.in_A;
      mem_b_q[wr_ptr_q] <= bus.in_B;
    end
  end

  assign bus.in_ready    = ~full;
  assign bus.input_ready = ~empty;
  assign bus.operand_A   = mem_a_q[rd_ptr_q];
  assign bus.operand_B   = mem_b_q[rd_ptr_q];
  assign bus.issue_cnt   = cnt_q;
`ifdef GCD_OPQ_LEVEL_EN
  assign bus.level       = occ_q;
`endif

endmodule

// File: tb/tb_gcd_operand_queue.sv
// Scoreboard bench for gcd_operand_queue: a queue-of-pairs reference model is
// updated on the falling edge and compared against every DUT output.
module tb_gcd_operand_queue;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   in_reset;
  int   checks = 0;
  int   errors = 0;

  pair_t       exp_q[$];
  logic [15:0] exp_cnt;

  gcd_operand_queue_if #(.width(W), .DEPTH(DEPTH)) bus ();

  gcd_operand_queue #(.width(W), .DEPTH(DEPTH)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic avail, input logic fl);
    bus.in_valid        = v;
    bus.in_A            = a;
    bus.in_B            = b;
    bus.input_available = avail;
    bus.flush           = fl;
  endtask

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return '0;
    return W'($urandom);
  endfunction

  // Reference model: inputs are stable at the falling edge, so the model
  // predicts the coming rising edge from its own queue contents.
  always @(negedge clk) begin : monitor
    bit    push_ok;
    pair_t p;
    if (in_reset) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      chk("in_ready", bus.in_ready, exp_q.size() < DEPTH);
      chk("input_ready", bus.input_ready, exp_q.size() > 0);
      chk("issue_cnt", bus.issue_cnt, exp_cnt);
`ifdef GCD_OPQ_LEVEL_EN
      chk("level", bus.level, exp_q.size());
`endif
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        push_ok = bus.in_valid && (exp_q.size() < DEPTH);
        if (exp_q.size() > 0 && bus.input_available) begin
          p = exp_q.pop_front();
          chk("operand_A", bus.operand_A, p.a);
          chk("operand_B", bus.operand_B, p.b);
          exp_cnt = exp_cnt + 16'd1;
        end
        if (push_ok) begin
          p.a = bus.in_A;
          p.b = bus.in_B;
          exp_q.push_back(p);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    in_reset = 1'b1;
    rst_n    = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_input_ready", bus.input_ready, 0);
    chk("rst_issue_cnt", bus.issue_cnt, 0);
    chk("rst_operand_A", bus.operand_A, 0);
    chk("rst_operand_B", bus.operand_B, 0);
    repeat (2) cycle();
    rst_n    = 1'b1;
    in_reset = 1'b0;
    cycle();

    // single pair reaches the core one cycle after the push
    drive(1'b1, 8'd48, 8'd18, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    chk("t2_issue_cnt", bus.issue_cnt, 1);
    chk("t2_input_ready", bus.input_ready, 0);

    // fill to full, fifth offer refused, then drain in order
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, W'(i), W'(10 + i), 1'b0, 1'b0);
      cycle();
    end
    chk("t3_full_in_ready", bus.in_ready, 0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (5) cycle();

    // steady push+pop at occupancy 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, W'(20 + i), W'(40 + i), 1'b0, 1'b0);
      cycle();
    end
    for (int i = 2; i < 8; i++) begin
      drive(1'b1, W'(20 + i), W'(40 + i), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) cycle();

    // flush with push and pop pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(60 + i), W'(70 + i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 8'd99, 8'd98, 1'b1, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t5_input_ready", bus.input_ready, 0);
    chk("t5_issue_cnt", bus.issue_cnt, 13);
    cycle();

    repeat (1500) begin
      drive($urandom_range(0, 9) < 6, rnd_op(), rnd_op(),
            $urandom_range(0, 9) < 5, $urandom_range(0, 31) == 0);
      cycle();
    end

    // asynchronous reset with pairs queued
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("t1_input_ready", bus.input_ready, 0);
    chk("t1_issue_cnt", bus.issue_cnt, 0);
    chk("t1_operand_A", bus.operand_A, 0);
    cycle();
    cycle();
    rst_n    = 1'b1;
    in_reset = 1'b0;
    cycle();
    chk("t1_in_ready", bus.in_ready, 1);

    // exactly 65536 pops from zero wraps the counter back to zero
    drive(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0);
    cycle();
    repeat (65535) begin
      drive(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t6_issue_cnt_wrap", bus.issue_cnt, 0);
    chk("t6_input_ready", bus.input_ready, 0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
